mem_data_port: RTL and testbench
================================

# mem_data_port

Memory data port for the datapath: owns the MAR and MDR registers and the request/acknowledge handshake to word-addressed memory. Sits directly upstream of the bus multiplexer; `mdr_out` is the multiplexer's MDR source (select 5'b10101), and `bus_in` is fed back from the multiplexer output. Control-unit strobes load MAR/MDR from the bus and start single-word reads or writes. Reads complete by loading the MDR from memory.

## Interface
- ADDR_W, 9, memory word-address width (512 words).
- DATA_W, 32, datapath/bus width.
- TIMEOUT, 255, maximum cycles `mem_req` is held without `mem_ack` (1..255).

- clk  in  1  rising-edge clock.
- clr  in  1  reset; one clock, reset asynchronous and active-high.
- bus_in  in  DATA_W  bus multiplexer output.
- mar_in  in  1  load MAR from `bus_in[ADDR_W-1:0]`.
- mdr_in  in  1  load MDR from `bus_in`.
- read  in  1  start a memory read (level sampled in IDLE).
- write  in  1  start a memory write (level sampled in IDLE).
- mem_ack  in  1  memory completion, valid only while `mem_req`=1.
- mem_rdata  in  DATA_W  read data, valid with `mem_ack`.
- mem_req  out  1  registered request.
- mem_we  out  1  registered; 1 = write request.
- mem_addr  out  ADDR_W  equals MAR.
- mem_wdata  out  DATA_W  equals MDR.
- mar_out  out  ADDR_W  MAR contents.
- mdr_out  out  DATA_W  MDR contents, to bus multiplexer.
- busy  out  1  1 in any state except IDLE.
- done  out  1  one-cycle pulse on transaction end (success or timeout).
- err  out  1  sticky timeout flag.

## Operation
- States: IDLE, REQ_RD, REQ_WR, DONE.
- IDLE: `read`=1 -> REQ_RD; else `write`=1 -> REQ_WR. Both high: read wins, write discarded.
- REQ_RD/REQ_WR: `mem_req`=1, `mem_we`=1 only in REQ_WR. Timeout counter clears on entry and increments each cycle without ack.
- Ack in REQ_RD: MDR <= `mem_rdata`, -> DONE. Ack in REQ_WR: -> DONE, MDR unchanged.
- No ack by the TIMEOUT-th request cycle: drop request, set `err`, -> DONE. On read timeout, MDR is unchanged.
- DONE: `done`=1 for one cycle, then -> IDLE. Commands presented in DONE are ignored.
- `err` clears when the next read/write is accepted in IDLE.
- `mar_in`/`mdr_in` are honoured only in IDLE; ignored while `busy`, so address and data stay stable during a transaction.
- `mar_in` plus a command in the same IDLE cycle: the transaction uses the newly loaded address. `mdr_in` plus `write` in the same cycle: the write uses the newly loaded data. `mdr_in` plus `read`: MDR loads the bus value, which is later overwritten by read data.
- `mem_ack` outside REQ states is ignored.
- `clr` asserted at any time: immediately IDLE; MAR, MDR, counter = 0; all outputs 0, including `mem_req` mid-transaction.

## Timing
- Reset values: `mem_req`, `mem_we`, `busy`, `done`, `err` = 0; `mem_addr`, `mar_out`, `mem_wdata`, `mdr_out` = 0.
- Command sampled at edge E0: `mem_req`=1 from E0 to the edge on which ack is sampled.
- `mem_ack` may be high in the first request cycle. Minimum read latency: MDR valid and `done`=1 in the cycle after E1, i.e. 2 cycles from command to `done`.
- Ack sampled at edge Ek: `mem_req`=0 and `done`=1 in the cycle after Ek. The next command can be accepted at Ek+2.
- Timeout: `mem_req` high for exactly TIMEOUT cycles, then `done`=`err`=1 together.
- MAR/MDR loads are visible on outputs one cycle after the load edge.

## Structure
- Shared package `datapath_pkg`: state enum `mdp_state_t`, constants ADDR_W/DATA_W defaults, MDR bus-select code 5'b10101.
- One sub-module: `mem_timeout_ctr` (8-bit counter with clear/enable and an `expired` flag at TIMEOUT-1).

## Test plan
- Reset mid-read: `clr` pulse while `mem_req`=1 -> `mem_req`, `busy`, MAR, MDR all 0 in the same cycle.
- `bus_in`=0x0000_0123, `mar_in`, then `read`; memory acks after 3 cycles with 0xDEAD_BEEF -> `mem_addr`=0x123, `mdr_out`=0xDEAD_BEEF, single `done` pulse, `err`=0.
- `bus_in`=0x0000_5A5A with `mdr_in` and `write` in the same cycle; immediate ack -> `mem_we`=1, `mem_wdata`=0x5A5A, `done` 2 cycles after the command.
- `read`+`write` both high -> `mem_we`=0 (read only). `mar_in` while `busy` -> `mar_out` unchanged.
- No ack with TIMEOUT=255 -> `mem_req` high exactly 255 cycles, then `done`=`err`=1, MDR unchanged; next `read` clears `err`.
- Back-to-back reads to 0x000 and 0x1FF -> second request starts at Ek+2; MDR shows each word in order.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath definitions: memory-port state encoding, default widths and
// the bus multiplexer select code that picks the MDR as bus source.
package datapath_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;
  localparam logic [4:0] BUS_SEL_MDR = 5'b10101;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ_RD = 2'b01,
    REQ_WR = 2'b10,
    DONE   = 2'b11
  } mdp_state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts request cycles without acknowledge; expired flags the last allowed
// request cycle so the port can abandon the transaction on that edge.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_data_port.sv
// Memory data port: MAR/MDR registers plus the single-word req/ack handshake
// to word-addressed memory, with request timeout and sticky error flag.
module mem_data_port
  import datapath_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              read,
  input  logic              write,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mar_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  mdp_state_t        state, state_nxt;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              ctr_clear, ctr_en, expired;
  logic              cmd_acc, timeout;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk     (clk),
    .clr     (clr),
    .clear   (ctr_clear),
    .en      (ctr_en),
    .expired (expired)
  );

  always_comb begin
    state_nxt = state;
    ctr_clear = 1'b0;
    ctr_en    = 1'b0;
    cmd_acc   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        ctr_clear = 1'b1;
        if (read) begin
          state_nxt = REQ_RD;
          cmd_acc   = 1'b1;
        end else if (write) begin
          state_nxt = REQ_WR;
          cmd_acc   = 1'b1;
        end
      end
      REQ_RD, REQ_WR: begin
        // A late ack on the expiry edge still counts as success.
        if (mem_ack) begin
          state_nxt = DONE;
        end else if (expired) begin
          state_nxt = DONE;
          timeout   = 1'b1;
        end else begin
          ctr_en = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered from next state so they change with it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      mem_req <= (state_nxt == REQ_RD) || (state_nxt == REQ_WR);
      mem_we  <= (state_nxt == REQ_WR);
      busy    <= (state_nxt != IDLE);
      done    <= (state_nxt == DONE);
      if (cmd_acc) begin
        err <= 1'b0;
      end else if (timeout) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mar <= '0;
      mdr <= '0;
    end else begin
      if (state == IDLE && mar_in) begin
        mar <= bus_in[ADDR_W-1:0];
      end
      if (state == IDLE && mdr_in) begin
        mdr <= bus_in;
      end else if (state == REQ_RD && mem_ack) begin
        mdr <= mem_rdata;
      end
    end
  end

  assign mem_addr  = mar;
  assign mar_out   = mar;
  assign mem_wdata = mdr;
  assign mdr_out   = mdr;

endmodule

// File: tb/tb_mem_data_port.sv
// Directed bench for mem_data_port: reset, read, write, priority, busy-time
// load blocking, timeout and back-to-back transactions.
module tb_mem_data_port;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              clr = 1'b0;
  logic [DATA_W-1:0] bus_in = '0;
  logic              mar_in = 1'b0;
  logic              mdr_in = 1'b0;
  logic              read = 1'b0;
  logic              write = 1'b0;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_req, mem_we, busy, done, err;
  logic [ADDR_W-1:0] mem_addr, mar_out;
  logic [DATA_W-1:0] mem_wdata, mdr_out;

  int checks = 0;
  int errors = 0;

  mem_data_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(255)) dut (
    .clk       (clk),
    .clr       (clr),
    .bus_in    (bus_in),
    .mar_in    (mar_in),
    .mdr_in    (mdr_in),
    .read      (read),
    .write     (write),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mar_out   (mar_out),
    .mdr_out   (mdr_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    tick();
    checks++;
    if ({mem_req, mem_we, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 00000", {mem_req, mem_we, busy, done, err});
    end
    checks++;
    if (mem_addr !== 9'h0 || mar_out !== 9'h0 || mem_wdata !== 32'h0 || mdr_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs got mar=%h mdr=%h expected 0", mar_out, mdr_out);
    end
    clr = 1'b0;
    // Load MAR/MDR, start a read, then reset while the request is up.
    bus_in = 32'h0000_0077; mar_in = 1'b1; mdr_in = 1'b1;
    tick();
    mar_in = 1'b0; mdr_in = 1'b0; read = 1'b1;
    tick();
    read = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mar_out !== 9'h077 || mdr_out !== 32'h77) begin
      errors++;
      $display("FAIL reset_setup got req=%b mar=%h mdr=%h expected 1 077 77", mem_req, mar_out, mdr_out);
    end
    #2 clr = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || mar_out !== 9'h0 || mdr_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_midread got req=%b busy=%b mar=%h mdr=%h expected 0", mem_req, busy, mar_out, mdr_out);
    end
    tick();
    clr = 1'b0;
    tick();
  endtask

  task automatic test_read();
    bus_in = 32'h0000_0123; mar_in = 1'b1;
    tick();
    mar_in = 1'b0;
    checks++;
    if (mar_out !== 9'h123) begin
      errors++;
      $display("FAIL mar_load got %h expected 123", mar_out);
    end
    read = 1'b1;
    tick();
    read = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b1 || mem_addr !== 9'h123) begin
      errors++;
      $display("FAIL read_req got req=%b we=%b busy=%b addr=%h expected 1 0 1 123", mem_req, mem_we, busy, mem_addr);
    end
    tick();
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    checks++;
    if (mem_req !== 1'b0 || done !== 1'b1 || mdr_out !== 32'hDEAD_BEEF || err !== 1'b0) begin
      errors++;
      $display("FAIL read_done got req=%b done=%b mdr=%h err=%b expected 0 1 deadbeef 0", mem_req, done, mdr_out, err);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || mdr_out !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_pulse got done=%b busy=%b mdr=%h expected 0 0 deadbeef", done, busy, mdr_out);
    end
  endtask

  task automatic test_write();
    bus_in = 32'h0000_5A5A; mdr_in = 1'b1; write = 1'b1;
    tick();
    mdr_in = 1'b0; write = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h5A5A) begin
      errors++;
      $display("FAIL write_req got req=%b we=%b wdata=%h expected 1 1 5a5a", mem_req, mem_we, mem_wdata);
    end
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    checks++;
    if (done !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || mdr_out !== 32'h5A5A) begin
      errors++;
      $display("FAIL write_done got done=%b req=%b we=%b mdr=%h expected 1 0 0 5a5a", done, mem_req, mem_we, mdr_out);
    end
    tick();
  endtask

  task automatic test_priority_busy();
    read = 1'b1; write = 1'b1;
    tick();
    read = 1'b0; write = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rd_wins got req=%b we=%b expected 1 0", mem_req, mem_we);
    end
    bus_in = 32'h0000_00AA; mar_in = 1'b1; mdr_in = 1'b1;
    tick();
    mar_in = 1'b0; mdr_in = 1'b0;
    checks++;
    if (mar_out !== 9'h123 || mdr_out !== 32'h5A5A) begin
      errors++;
      $display("FAIL busy_load got mar=%h mdr=%h expected 123 5a5a", mar_out, mdr_out);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    checks++;
    if (done !== 1'b1 || mdr_out !== 32'h1111_2222) begin
      errors++;
      $display("FAIL prio_read got done=%b mdr=%h expected 1 11112222", done, mdr_out);
    end
    tick();
  endtask

  task automatic test_timeout();
    int cnt;
    read = 1'b1;
    tick();
    read = 1'b0;
    cnt = 0;
    while (mem_req === 1'b1 && cnt < 300) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 255) begin
      errors++;
      $display("FAIL to_len got %0d cycles expected 255", cnt);
    end
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || mdr_out !== 32'h1111_2222) begin
      errors++;
      $display("FAIL to_end got done=%b err=%b mdr=%h expected 1 1 11112222", done, err, mdr_out);
    end
    tick();
    checks++;
    if (done !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_sticky got done=%b err=%b busy=%b expected 0 1 0", done, err, busy);
    end
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    checks++;
    if (mdr_out !== 32'h1111_2222 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack got mdr=%h busy=%b done=%b expected 11112222 0 0", mdr_out, busy, done);
    end
    read = 1'b1;
    tick();
    read = 1'b0;
    checks++;
    if (err !== 1'b0 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL err_clear got err=%b req=%b expected 0 1", err, mem_req);
    end
    mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
    tick();
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bus_in = 32'h0; mar_in = 1'b1;
    tick();
    mar_in = 1'b0; read = 1'b1;
    tick();
    read = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 9'h000) begin
      errors++;
      $display("FAIL b2b_req1 got req=%b addr=%h expected 1 000", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_0001;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || mdr_out !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL b2b_done1 got done=%b mdr=%h expected 1 aaaa0001", done, mdr_out);
    end
    // Command presented during DONE: ignored there, accepted on the next edge.
    bus_in = 32'h0000_01FF; mar_in = 1'b1; read = 1'b1;
    tick();
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || mar_out !== 9'h000) begin
      errors++;
      $display("FAIL b2b_gap got req=%b busy=%b mar=%h expected 0 0 000", mem_req, busy, mar_out);
    end
    tick();
    mar_in = 1'b0; read = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 9'h1FF) begin
      errors++;
      $display("FAIL b2b_req2 got req=%b addr=%h expected 1 1ff", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'hBBBB_0002;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || mdr_out !== 32'hBBBB_0002) begin
      errors++;
      $display("FAIL b2b_done2 got done=%b mdr=%h expected 1 bbbb0002", done, mdr_out);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_priority_busy();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
